// File: rtl/regs_mp_pkg.sv
// Shared limits and bus-slicing helpers for the regs_mp register file.
// Combinational helpers only; no timing or flow-control content.
package regs_mp_pkg;

    localparam int MAX_NR = 4;
    localparam int MAX_NW = 2;

    // Low bit of port 'idx' in a flattened bus of 'w'-bit fields.
    function automatic int slice_lo(input int idx, input int w);
        return idx * w;
    endfunction

    function automatic bit is_pow2(input int n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/regs_mp_if.sv
// Decode/writeback-facing bus of regs_mp: read ports, write ports, reserve and scoreboard view.
// No handshaking; every request is taken on the edge it is presented.
interface regs_mp_if #(
    parameter int DW    = 16,
    parameter int DEPTH = 16,
    parameter int NR    = 2,
    parameter int NW    = 1
);
    localparam int AW = $clog2(DEPTH);

    logic [NR-1:0]    ren;
    logic [NR*AW-1:0] raddr;
    logic [NR*DW-1:0] rdata;
    logic [NR-1:0]    rvalid;
    logic [NR-1:0]    rbusy;
    logic [NW-1:0]    wen;
    logic [NW*AW-1:0] waddr;
    logic [NW*DW-1:0] wdata;
    logic             rsv_en;
    logic [AW-1:0]    rsv_addr;
    logic [DEPTH-1:0] busy_vec;

    modport master (
        output ren, raddr, wen, waddr, wdata, rsv_en, rsv_addr,
        input  rdata, rvalid, rbusy, busy_vec
    );

    modport slave (
        input  ren, raddr, wen, waddr, wdata, rsv_en, rsv_addr,
        output rdata, rvalid, rbusy, busy_vec
    );

endinterface

// File: rtl/regs_mp_wmerge.sv
// Resolves NW write ports against one address into a hit flag and winning data (highest port wins).
// Purely combinational; no backpressure.
module regs_mp_wmerge
    import regs_mp_pkg::*;
#(
    parameter int DW = 16,
    parameter int AW = 4,
    parameter int NW = 1
) (
    input  logic [AW-1:0]    addr_i,
    input  logic [NW-1:0]    wen_i,
    input  logic [NW*AW-1:0] waddr_i,
    input  logic [NW*DW-1:0] wdata_i,
    output logic             hit_o,
    output logic [DW-1:0]    dat_o
);

    // Ascending scan: a later matching port overrides an earlier one.
    always_comb begin
        hit_o = 1'b0;
        dat_o = '0;
        for (int j = 0; j < NW; j++) begin
            if (wen_i[j] && (waddr_i[slice_lo(j, AW) +: AW] == addr_i)) begin
                hit_o = 1'b1;
                dat_o = wdata_i[slice_lo(j, DW) +: DW];
            end
        end
    end

endmodule

// File: rtl/regs_mp.sv
// regs_mp: NR-read/NW-write register file with busy scoreboard; REGS_MP_BYPASS_EN adds write-to-read bypass.
// Reads return one cycle after ren; no backpressure, every request is accepted every cycle.
module regs_mp
    import regs_mp_pkg::*;
#(
    parameter int DW       = 16,
    parameter int DEPTH    = 16,
    parameter int NR       = 2,
    parameter int NW       = 1,
    parameter int ZERO_REG = 0
) (
    input logic       clk,
    input logic       rst_n,
    regs_mp_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);
    localparam bit ZR = (ZERO_REG != 0);

    if (NR < 1 || NR > MAX_NR) begin : g_bad_nr
        $error("regs_mp: NR out of range");
    end
    if (NW < 1 || NW > MAX_NW) begin : g_bad_nw
        $error("regs_mp: NW out of range");
    end
    if (!is_pow2(DEPTH)) begin : g_bad_depth
        $error("regs_mp: DEPTH must be a power of two >= 2");
    end

    logic [DW-1:0]    mem_q   [DEPTH];
    logic [DW-1:0]    mem_d   [DEPTH];
    logic [DW-1:0]    ent_dat [DEPTH];
    logic [DEPTH-1:0] ent_hit;
    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    for (genvar e = 0; e < DEPTH; e++) begin : g_ent
        localparam logic [AW-1:0] EADDR = AW'(e);
        localparam bit            ZENT  = ZR && (e == 0);

        regs_mp_wmerge #(.DW(DW), .AW(AW), .NW(NW)) u_wmerge (
            .addr_i  (EADDR),
            .wen_i   (bus.wen),
            .waddr_i (bus.waddr),
            .wdata_i (bus.wdata),
            .hit_o   (ent_hit[e]),
            .dat_o   (ent_dat[e])
        );

        assign mem_d[e]  = ZENT ? '0 : (ent_hit[e] ? ent_dat[e] : mem_q[e]);
        // Clear on write, then set on reserve: a new producer outranks the retiring one.
        assign busy_d[e] = ZENT ? 1'b0
                         : ((busy_q[e] & ~ent_hit[e]) | (bus.rsv_en && (bus.rsv_addr == EADDR)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
            busy_q <= '0;
        end else begin
            for (int k = 0; k < DEPTH; k++) mem_q[k] <= mem_d[k];
            busy_q <= busy_d;
        end
    end

    logic [DW-1:0] rdata_d [NR];
    logic [DW-1:0] rdata_q [NR];
    logic [NR-1:0] rbusy_d;
    logic [NR-1:0] rbusy_q;
    logic [NR-1:0] rvalid_q;

    for (genvar i = 0; i < NR; i++) begin : g_rd
        logic [AW-1:0] ra;
        logic          zhit;

        assign ra   = bus.raddr[slice_lo(i, AW) +: AW];
        assign zhit = ZR && (ra == '0);

`ifdef REGS_MP_BYPASS_EN
        logic          byp_hit;
        logic [DW-1:0] byp_dat;

        regs_mp_wmerge #(.DW(DW), .AW(AW), .NW(NW)) u_byp (
            .addr_i  (ra),
            .wen_i   (bus.wen),
            .waddr_i (bus.waddr),
            .wdata_i (bus.wdata),
            .hit_o   (byp_hit),
            .dat_o   (byp_dat)
        );

        assign rdata_d[i] = zhit ? '0 : (byp_hit ? byp_dat : mem_q[ra]);
        assign rbusy_d[i] = zhit ? 1'b0 : busy_d[ra];
`else
        assign rdata_d[i] = zhit ? '0 : mem_q[ra];
        assign rbusy_d[i] = zhit ? 1'b0 : busy_q[ra];
`endif

        assign bus.rdata[slice_lo(i, DW) +: DW] = rdata_q[i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NR; k++) rdata_q[k] <= '0;
            rbusy_q  <= '0;
            rvalid_q <= '0;
        end else begin
            rvalid_q <= bus.ren;
            for (int k = 0; k < NR; k++) begin
                if (bus.ren[k]) begin
                    rdata_q[k] <= rdata_d[k];
                    rbusy_q[k] <= rbusy_d[k];
                end
            end
        end
    end

    assign bus.rvalid   = rvalid_q;
    assign bus.rbusy    = rbusy_q;
    assign bus.busy_vec = busy_q;

endmodule

// File: tb/tb_regs_mp.sv
// Directed bench for regs_mp: a 2-write-port instance and a ZERO_REG instance on shared clock/reset.
// Read data is expected one edge after ren; inputs change 1 time unit after each rising edge.
module tb_regs_mp;

    localparam int DW    = 16;
    localparam int DEPTH = 16;
    localparam int NR    = 2;

`ifdef REGS_MP_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   vecs  = 0;
    int   errs  = 0;

    always #5 clk = ~clk;

    regs_mp_if #(.DW(DW), .DEPTH(DEPTH), .NR(NR), .NW(2)) ifa ();
    regs_mp_if #(.DW(DW), .DEPTH(DEPTH), .NR(NR), .NW(1)) ifz ();

    regs_mp #(.DW(DW), .DEPTH(DEPTH), .NR(NR), .NW(2), .ZERO_REG(0)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa)
    );

    regs_mp #(.DW(DW), .DEPTH(DEPTH), .NR(NR), .NW(1), .ZERO_REG(1)) u_dut_z (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifz)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ifa.ren = '0; ifa.raddr = '0; ifa.wen = '0; ifa.waddr = '0; ifa.wdata = '0;
        ifa.rsv_en = 1'b0; ifa.rsv_addr = '0;
        ifz.ren = '0; ifz.raddr = '0; ifz.wen = '0; ifz.waddr = '0; ifz.wdata = '0;
        ifz.rsv_en = 1'b0; ifz.rsv_addr = '0;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        step(); step();
        vecs++;
        if ({ifa.busy_vec, ifa.rvalid, ifa.rbusy, ifa.rdata, ifz.busy_vec, ifz.rdata} !== '0) begin
            errs++;
            $display("FAIL reset_state: got a=%h/%b/%b/%h z=%h/%h required all zero",
                     ifa.busy_vec, ifa.rvalid, ifa.rbusy, ifa.rdata, ifz.busy_vec, ifz.rdata);
        end
        rst_n = 1'b1;
        step();
        ifa.wen = 2'b01; ifa.waddr[3:0] = 4'd3; ifa.wdata[15:0] = 16'hBEEF;
        ifa.rsv_en = 1'b1; ifa.rsv_addr = 4'd6;
        step();
        idle();
        ifa.ren = 2'b01; ifa.raddr[3:0] = 4'd3;
        step();
        vecs++;
        if (ifa.rdata[15:0] !== 16'hBEEF || ifa.busy_vec !== 16'h0040) begin
            errs++;
            $display("FAIL pre_reset_read: got rdata=%h busy=%h required BEEF/0040",
                     ifa.rdata[15:0], ifa.busy_vec);
        end
        idle();
        #2 rst_n = 1'b0;
        #1;
        vecs++;
        if ({ifa.busy_vec, ifa.rvalid, ifa.rdata} !== '0) begin
            errs++;
            $display("FAIL async_reset: got busy=%h rvalid=%b rdata=%h required zeros",
                     ifa.busy_vec, ifa.rvalid, ifa.rdata);
        end
        step();
        rst_n = 1'b1;
        step();
        ifa.ren = 2'b01; ifa.raddr[3:0] = 4'd3;
        step();
        vecs++;
        if (ifa.rdata[15:0] !== 16'h0000 || ifa.rbusy[0] !== 1'b0 ||
            ifa.rvalid !== 2'b01 || ifa.busy_vec !== 16'h0000) begin
            errs++;
            $display("FAIL post_reset_read: got rdata=%h rbusy=%b rvalid=%b busy=%h required 0000/0/01/0000",
                     ifa.rdata[15:0], ifa.rbusy[0], ifa.rvalid, ifa.busy_vec);
        end
        idle();
    endtask

    task automatic test_basic();
        idle();
        ifa.wen = 2'b01; ifa.waddr[3:0] = 4'd5; ifa.wdata[15:0] = 16'h1234;
        step();
        idle();
        ifa.ren = 2'b01; ifa.raddr[3:0] = 4'd5;
        step();
        vecs++;
        if (ifa.rdata[15:0] !== 16'h1234 || ifa.rvalid !== 2'b01) begin
            errs++;
            $display("FAIL basic_read: got rdata=%h rvalid=%b required 1234/01", ifa.rdata[15:0], ifa.rvalid);
        end
        idle();
        step();
        vecs++;
        if (ifa.rdata[15:0] !== 16'h1234 || ifa.rvalid !== 2'b00) begin
            errs++;
            $display("FAIL basic_hold: got rdata=%h rvalid=%b required 1234/00", ifa.rdata[15:0], ifa.rvalid);
        end
        ifa.wen = 2'b11; ifa.waddr = {4'd15, 4'd0}; ifa.wdata = {16'hCAFE, 16'h0F0F};
        step();
        idle();
        ifa.ren = 2'b11; ifa.raddr = {4'd0, 4'd15};
        step();
        vecs++;
        if (ifa.rdata !== {16'h0F0F, 16'hCAFE} || ifa.rvalid !== 2'b11) begin
            errs++;
            $display("FAIL dual_port_read: got rdata=%h rvalid=%b required 0f0fcafe/11", ifa.rdata, ifa.rvalid);
        end
        ifa.raddr = {4'd5, 4'd5};
        step();
        vecs++;
        if (ifa.rdata !== {16'h1234, 16'h1234}) begin
            errs++;
            $display("FAIL same_addr_read: got rdata=%h required 12341234", ifa.rdata);
        end
        ifa.ren = 2'b10; ifa.raddr = {4'd0, 4'd5};
        step();
        vecs++;
        if (ifa.rdata !== {16'h0F0F, 16'h1234} || ifa.rvalid !== 2'b10) begin
            errs++;
            $display("FAIL port_indep: got rdata=%h rvalid=%b required 0f0f1234/10", ifa.rdata, ifa.rvalid);
        end
        idle();
    endtask

    task automatic test_collision();
        idle();
        ifa.wen = 2'b11; ifa.waddr = {4'd7, 4'd7}; ifa.wdata = {16'h5555, 16'hAAAA};
        step();
        idle();
        ifa.ren = 2'b01; ifa.raddr[3:0] = 4'd7;
        step();
        vecs++;
        if (ifa.rdata[15:0] !== 16'h5555) begin
            errs++;
            $display("FAIL collision: got rdata=%h required 5555", ifa.rdata[15:0]);
        end
        idle();
        ifa.wen = 2'b01; ifa.waddr[3:0] = 4'd7; ifa.wdata[15:0] = 16'h1111;
        step();
        idle();
        ifa.ren = 2'b10; ifa.raddr[7:4] = 4'd7;
        step();
        vecs++;
        if (ifa.rdata[31:16] !== 16'h1111) begin
            errs++;
            $display("FAIL port0_write: got rdata=%h required 1111", ifa.rdata[31:16]);
        end
        idle();
    endtask

    task automatic test_scoreboard();
        idle();
        ifa.rsv_en = 1'b1; ifa.rsv_addr = 4'd9;
        step();
        idle();
        vecs++;
        if (ifa.busy_vec !== 16'h0200) begin
            errs++;
            $display("FAIL reserve: got busy=%h required 0200", ifa.busy_vec);
        end
        ifa.ren = 2'b01; ifa.raddr[3:0] = 4'd9;
        step();
        vecs++;
        if (ifa.rbusy[0] !== 1'b1) begin
            errs++;
            $display("FAIL rbusy_set: got %b required 1", ifa.rbusy[0]);
        end
        idle();
        ifa.wen = 2'b01; ifa.waddr[3:0] = 4'd9; ifa.wdata[15:0] = 16'h0999;
        step();
        vecs++;
        if (ifa.busy_vec !== 16'h0000) begin
            errs++;
            $display("FAIL write_clears: got busy=%h required 0000", ifa.busy_vec);
        end
        ifa.rsv_en = 1'b1; ifa.rsv_addr = 4'd9;
        step();
        vecs++;
        if (ifa.busy_vec !== 16'h0200) begin
            errs++;
            $display("FAIL rsv_wins: got busy=%h required 0200", ifa.busy_vec);
        end
        idle();
        ifa.wen = 2'b10; ifa.waddr[7:4] = 4'd9; ifa.wdata[31:16] = 16'h0AAA;
        step();
        idle();
        ifa.ren = 2'b01; ifa.raddr[3:0] = 4'd9;
        step();
        vecs++;
        if (ifa.busy_vec !== 16'h0000 || ifa.rbusy[0] !== 1'b0 || ifa.rdata[15:0] !== 16'h0AAA) begin
            errs++;
            $display("FAIL port1_clears: got busy=%h rbusy=%b rdata=%h required 0000/0/0aaa",
                     ifa.busy_vec, ifa.rbusy[0], ifa.rdata[15:0]);
        end
        idle();
    endtask

    task automatic test_same_cycle();
        logic [15:0] exp_d;
        idle();
        ifa.wen = 2'b01; ifa.waddr[3:0] = 4'd4; ifa.wdata[15:0] = 16'h0011;
        step();
        ifa.wdata[15:0] = 16'h0022;
        ifa.ren = 2'b01; ifa.raddr[3:0] = 4'd4;
        step();
        exp_d = BYP ? 16'h0022 : 16'h0011;
        vecs++;
        if (ifa.rdata[15:0] !== exp_d) begin
            errs++;
            $display("FAIL rw_same_cycle: got rdata=%h required %h", ifa.rdata[15:0], exp_d);
        end
        idle();
        ifa.ren = 2'b01; ifa.raddr[3:0] = 4'd4;
        step();
        vecs++;
        if (ifa.rdata[15:0] !== 16'h0022) begin
            errs++;
            $display("FAIL rw_after: got rdata=%h required 0022", ifa.rdata[15:0]);
        end
        ifa.rsv_en = 1'b1; ifa.rsv_addr = 4'd4;
        step();
        vecs++;
        if (ifa.rbusy[0] !== BYP || ifa.busy_vec !== 16'h0010) begin
            errs++;
            $display("FAIL rsv_read_same: got rbusy=%b busy=%h required %b/0010", ifa.rbusy[0], ifa.busy_vec, BYP);
        end
        idle();
        ifa.wen = 2'b01; ifa.waddr[3:0] = 4'd4; ifa.wdata[15:0] = 16'h0033;
        step();
        ifa.wen = 2'b11; ifa.waddr = {4'd4, 4'd4}; ifa.wdata = {16'h0055, 16'h0044};
        ifa.ren = 2'b01; ifa.raddr[3:0] = 4'd4;
        step();
        exp_d = BYP ? 16'h0055 : 16'h0033;
        vecs++;
        if (ifa.rdata[15:0] !== exp_d || ifa.busy_vec !== 16'h0000) begin
            errs++;
            $display("FAIL rw_collision: got rdata=%h busy=%h required %h/0000", ifa.rdata[15:0], ifa.busy_vec, exp_d);
        end
        idle();
    endtask

    task automatic test_zero_reg();
        idle();
        ifz.wen = 1'b1; ifz.waddr = 4'd0; ifz.wdata = 16'hFFFF;
        ifz.rsv_en = 1'b1; ifz.rsv_addr = 4'd0;
        step();
        idle();
        vecs++;
        if (ifz.busy_vec !== 16'h0000) begin
            errs++;
            $display("FAIL zero_busy: got busy=%h required 0000", ifz.busy_vec);
        end
        ifz.ren = 2'b11; ifz.raddr = {4'd0, 4'd0};
        step();
        vecs++;
        if (ifz.rdata !== 32'h0 || ifz.rbusy !== 2'b00 || ifz.rvalid !== 2'b11) begin
            errs++;
            $display("FAIL zero_read: got rdata=%h rbusy=%b rvalid=%b required 0/00/11",
                     ifz.rdata, ifz.rbusy, ifz.rvalid);
        end
        idle();
        ifz.wen = 1'b1; ifz.waddr = 4'd1; ifz.wdata = 16'hABCD;
        ifz.rsv_en = 1'b1; ifz.rsv_addr = 4'd2;
        step();
        idle();
        vecs++;
        if (ifz.busy_vec !== 16'h0004) begin
            errs++;
            $display("FAIL zero_other_rsv: got busy=%h required 0004", ifz.busy_vec);
        end
        ifz.ren = 2'b11; ifz.raddr = {4'd1, 4'd0};
        ifz.wen = 1'b1; ifz.waddr = 4'd0; ifz.wdata = 16'h1234;
        step();
        vecs++;
        if (ifz.rdata !== {16'hABCD, 16'h0000}) begin
            errs++;
            $display("FAIL zero_rw_same: got rdata=%h required abcd0000", ifz.rdata);
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_basic();
        test_collision();
        test_scoreboard();
        test_same_cycle();
        test_zero_reg();
        step();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/regs_mp.md
Name: regs_mp

Overview:
- Parametrised multi-port register file; successor to the single-clock 2-read/1-write regs block.
- Sits between decode (reads/reservations) and writeback (writes) in the pipelined core.
- Adds configurable width, depth and port counts, a registered 1-cycle read, and a per-entry busy scoreboard for hazard detection.
- Adds a hardwired zero register and optional write-to-read bypass.

Parameters:
- DW, 16, data width in bits.
- DEPTH, 16, number of entries; power of two, minimum 2.
- AW, $clog2(DEPTH), address width; derived, not overridden.
- NR, 2, read port count (1..4).
- NW, 1, write port count (1..2).
- ZERO_REG, 0, if 1 then entry 0 always reads 0, and writes and reservations to it are ignored.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous reset, active low.
- ren  in  NR  per-port read request.
- raddr  in  NR*AW  read addresses; port i occupies bits [i*AW +: AW].
- rdata  out  NR*DW  registered read data; port i occupies bits [i*DW +: DW].
- rvalid  out  NR  high for one cycle when rdata[i] carries a new result.
- rbusy  out  NR  registered busy flag of the entry that was read.
- wen  in  NW  per-port write enable.
- waddr  in  NW*AW  write addresses.
- wdata  in  NW*DW  write data.
- rsv_en  in  1  reserve request: marks an entry busy (pending producer).
- rsv_addr  in  AW  entry to reserve.
- busy_vec  out  DEPTH  current scoreboard state, driven directly from flops.

Behaviour:
- Reset (rst_n low, asynchronous): all entries, rdata, rvalid, rbusy and busy_vec go to 0. Reset has priority over every other input. Deassertion takes effect at the next clk edge.
- Read latency is one cycle. If ren[i] is sampled high at edge N, then after edge N rdata[i] = entry[raddr[i]], rbusy[i] = busy[raddr[i]], and rvalid[i] = 1 for exactly one cycle.
- When ren[i] is low, rdata[i] and rbusy[i] hold their previous values and rvalid[i] = 0.
- All NR read ports are independent. Any ports may read the same address in the same cycle.
- Write: when wen[j] is high at an edge, entry[waddr[j]] is updated with wdata[j] at that edge.
- Write collision: if two write ports target the same address in one cycle, the higher port index wins. This is a defined case, not an error.
- Scoreboard update order within one edge:
  - Busy bits are cleared for every written address.
  - The busy bit is then set for rsv_addr if rsv_en is high.
  - Therefore a reserve and a write to the same address in the same cycle leave the entry busy (the new producer wins).
- ZERO_REG=1: reads of address 0 return 0 with rbusy = 0. Writes and reservations to address 0 have no effect. busy_vec[0] is always 0.
- Same-cycle read and write to the same address, without bypass: the read returns the old entry value and the pre-update busy bit.
- Addresses are always in range, because DEPTH = 2^AW. There is no wrap or out-of-range handling.

Optional Feature:
- Macro REGS_MP_BYPASS_EN.
- When defined:
  - A read sampled in the same cycle as a write to the same address returns the winning wdata.
  - rbusy is then computed from the post-clear, post-reserve busy value.
  - ZERO_REG still forces 0 on address 0.
- When undefined: read-before-write semantics as stated in Behaviour. Area is lower and there is no combinational path from wdata to the read flops.

Decomposition:
- Package regs_mp_pkg holds:
  - the port-count limits MAX_NR = 4 and MAX_NW = 2;
  - helper functions for slicing the flattened address and data buses.
- One sub-module, regs_mp_wmerge. For a given address it resolves the NW write ports into a single hit flag and the winning data (highest index wins).
- regs_mp_wmerge is instantiated once per entry for storage update, and once per read port when REGS_MP_BYPASS_EN is defined.

Test Plan:
- Reset: hold rst_n low mid-run after writing 0xBEEF to entry 3. After release, reading entry 3 returns rdata 0x0000, rbusy 0, and busy_vec is all zeros.
- Basic read/write: write 0x1234 to entry 5 at edge N. Read entry 5 with ren at edge N+1. At N+2, rdata = 0x1234 and rvalid is high for exactly one cycle.
- Collision: NW=2, with port 0 writing 0xAAAA and port 1 writing 0x5555 to entry 7 in the same cycle. A subsequent read of entry 7 returns 0x5555.
- Scoreboard: reserve entry 9, giving busy_vec[9] = 1. Read entry 9 returns rbusy = 1. Write entry 9 clears busy_vec[9] to 0. A reserve plus write to 9 in the same cycle leaves busy_vec[9] = 1.
- Same-cycle read/write to entry 4, with old value 0x0011 and new value 0x0022: without the macro, rdata = 0x0011; with REGS_MP_BYPASS_EN defined, rdata = 0x0022.
- ZERO_REG=1: write 0xFFFF to entry 0 and reserve entry 0. Reading entry 0 returns rdata 0x0000, rbusy 0, and busy_vec[0] = 0.
